// File: rtl/cycle_detect.sv
// Negative-cycle detector run after Bellman-Ford relaxation. It scans every edge for a
// still-relaxable one, walks predecessors onto the cycle, then streams the cycle's vertices.
module cycle_detect #(
  parameter int NODES    = 16,
  parameter int IDX_W    = 4,
  parameter int WEIGHT_W = 32
) (
  input  logic                      clk,
  input  logic                      detect_reset,
  input  logic                      bellman_done,
  output logic [IDX_W-1:0]          vertmat_addr_a,
  output logic [IDX_W-1:0]          vertmat_addr_b,
  input  logic [IDX_W+WEIGHT_W-1:0] vertmat_q_a,
  input  logic [IDX_W+WEIGHT_W-1:0] vertmat_q_b,
  output logic [IDX_W-1:0]          adjmat_row_addr,
  output logic [IDX_W-1:0]          adjmat_col_addr,
  input  logic [WEIGHT_W-1:0]       adjmat_q,
  output logic [IDX_W-1:0]          cyc_vertex,
  output logic                      cyc_valid,
  output logic                      cyc_last,
  input  logic                      cyc_ready,
  output logic                      cycle_found,
  output logic                      cycle_error,
  output logic                      detect_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK_ADDR, S_CHECK_CMP, S_WALK_ADDR, S_WALK_STEP, S_EMIT, S_DONE
  } state_e;

  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NODES - 1);
  localparam logic [WEIGHT_W-1:0] INF_W    = {1'b0, {(WEIGHT_W-1){1'b1}}};

  state_e           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d, v_q, v_d, n_q, n_d;
  logic [IDX_W-1:0] start_q, start_d, pred_q, pred_d, vtx_q, vtx_d;
  logic             wait_q, wait_d, vld_q, vld_d, last_q, last_d;
  logic             found_q, found_d, err_q, err_d;

  logic [IDX_W-1:0]        pred_a;
  logic [WEIGHT_W-1:0]     svw, dvw;
  logic signed [WEIGHT_W:0] sum_w, dvw_x;
  logic                    violation, fire;
  logic                    unused_pred_b;

  assign pred_a        = vertmat_q_a[IDX_W+WEIGHT_W-1 -: IDX_W];
  assign svw           = vertmat_q_a[WEIGHT_W-1:0];
  assign dvw           = vertmat_q_b[WEIGHT_W-1:0];
  assign unused_pred_b = ^vertmat_q_b[IDX_W+WEIGHT_W-1 -: IDX_W];

  // One extra bit so svw+e cannot wrap before the compare.
  assign sum_w     = $signed({svw[WEIGHT_W-1], svw}) + $signed({adjmat_q[WEIGHT_W-1], adjmat_q});
  assign dvw_x     = $signed({dvw[WEIGHT_W-1], dvw});
  assign violation = (adjmat_q != '0) && (svw != INF_W) && (sum_w < dvw_x);
  assign fire      = vld_q & cyc_ready;

  always_ff @(posedge clk) begin
    if (detect_reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      v_q     <= '0;
      n_q     <= '0;
      start_q <= '0;
      pred_q  <= '0;
      vtx_q   <= '0;
      wait_q  <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      found_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      v_q     <= v_d;
      n_q     <= n_d;
      start_q <= start_d;
      pred_q  <= pred_d;
      vtx_q   <= vtx_d;
      wait_q  <= wait_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      found_q <= found_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    v_d     = v_q;
    n_d     = n_q;
    start_d = start_q;
    pred_d  = pred_q;
    vtx_d   = vtx_q;
    wait_d  = wait_q;
    vld_d   = vld_q;
    last_d  = last_q;
    found_d = found_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (bellman_done) begin
        state_d = S_CHECK_ADDR;
        i_d     = '0;
        j_d     = '0;
      end
      S_CHECK_ADDR: state_d = S_CHECK_CMP;
      S_CHECK_CMP: begin
        if (violation) begin
          v_d     = j_q;
          n_d     = '0;
          state_d = S_WALK_ADDR;
        end else if (j_q == LAST_IDX) begin
          j_d = '0;
          if (i_q == LAST_IDX) begin
            found_d = 1'b0;
            state_d = S_DONE;
          end else begin
            i_d     = i_q + IDX_W'(1);
            state_d = S_CHECK_ADDR;
          end
        end else begin
          j_d     = j_q + IDX_W'(1);
          state_d = S_CHECK_ADDR;
        end
      end
      S_WALK_ADDR: state_d = S_WALK_STEP;
      S_WALK_STEP: begin
        v_d = pred_a;
        if (n_q == LAST_IDX) begin
          n_d     = '0;
          start_d = pred_a;
          wait_d  = 1'b0;
          state_d = S_EMIT;
        end else begin
          n_d     = n_q + IDX_W'(1);
          state_d = S_WALK_ADDR;
        end
      end
      S_EMIT: begin
        // wait_q marks the cycle in which pred(v) is on port A.
        if (vld_q) begin
          if (cyc_ready) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
            v_d    = pred_q;
            n_d    = n_q + IDX_W'(1);
            wait_d = 1'b1;
            if (last_q) begin
              found_d = 1'b1;
              state_d = S_DONE;
            end else if (n_q == LAST_IDX) begin
              err_d   = 1'b1;
              found_d = 1'b0;
              state_d = S_DONE;
            end
          end
        end else if (wait_q) begin
          vld_d  = 1'b1;
          vtx_d  = v_q;
          pred_d = pred_a;
          last_d = (pred_a == start_q);
          wait_d = 1'b0;
        end else begin
          wait_d = 1'b1;
        end
      end
      S_DONE:  ;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vertmat_addr_a = i_q;
    case (state_q)
      S_WALK_ADDR, S_WALK_STEP: vertmat_addr_a = v_q;
      S_EMIT:                   vertmat_addr_a = fire ? pred_q : v_q;
      default: ;
    endcase
  end

  assign vertmat_addr_b  = j_q;
  assign adjmat_row_addr = i_q;
  assign adjmat_col_addr = j_q;
  assign cyc_vertex      = vtx_q;
  assign cyc_valid       = vld_q;
  assign cyc_last        = last_q;
  assign cycle_found     = found_q;
  assign cycle_error     = err_q;
  assign detect_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_cycle_detect.sv
// Bench for cycle_detect: directed scenarios, an edge-compare vector table, and random graphs
// checked against a queue-based model of scan / walk / emit.
module tb_cycle_detect;
  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int WW  = 32;
  localparam int INF = 32'h7FFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic detect_reset = 1'b1, bellman_done = 1'b0, cyc_ready = 1'b1;
  logic [IW-1:0] addr_a, addr_b, row, col, cyc_vertex;
  logic [IW+WW-1:0] vq_a, vq_b;
  logic [WW-1:0] aq;
  logic cyc_valid, cyc_last, cycle_found, cycle_error, detect_done;

  cycle_detect #(.NODES(N), .IDX_W(IW), .WEIGHT_W(WW)) dut (
    .clk(clk), .detect_reset(detect_reset), .bellman_done(bellman_done),
    .vertmat_addr_a(addr_a), .vertmat_addr_b(addr_b),
    .vertmat_q_a(vq_a), .vertmat_q_b(vq_b),
    .adjmat_row_addr(row), .adjmat_col_addr(col), .adjmat_q(aq),
    .cyc_vertex(cyc_vertex), .cyc_valid(cyc_valid), .cyc_last(cyc_last),
    .cyc_ready(cyc_ready), .cycle_found(cycle_found), .cycle_error(cycle_error),
    .detect_done(detect_done)
  );

  logic [IW-1:0] vpred[N];
  int vw[N];
  int adj[N][N];

  always @(posedge clk) begin
    vq_a <= {vpred[addr_a], vw[addr_a]};
    vq_b <= {vpred[addr_b], vw[addr_b]};
    aq   <= adj[row][col];
  end

  typedef struct { logic [IW-1:0] vtx; logic last; } beat_t;
  typedef struct { logic [31:0] sw; logic [31:0] e; logic [31:0] dw; bit found; } vec_t;

  beat_t beats[$];
  int    exp_v[$];
  bit    exp_found;
  int    checks = 0, failures = 0;
  int    ready_mode = 0, stall_cnt = 0, valid_cycles = 0;
  logic  hold_pend = 1'b0, hold_last;
  logic [IW-1:0] hold_vtx;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (detect_reset) hold_pend = 1'b0;
    else begin
      if (hold_pend) chk("stall_hold", {cyc_valid, cyc_last, cyc_vertex}, {1'b1, hold_last, hold_vtx});
      if (cyc_valid) valid_cycles++;
      if (cyc_valid && cyc_ready) beats.push_back('{cyc_vertex, cyc_last});
      hold_pend = cyc_valid && !cyc_ready;
      hold_vtx  = cyc_vertex;
      hold_last = cyc_last;
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: cyc_ready = 1'b1;
      1: cyc_ready = ($urandom_range(0, 2) != 0);
      default:
        if (cyc_valid && beats.size() == 1 && stall_cnt < 5) begin
          cyc_ready = 1'b0;
          stall_cnt++;
        end else cyc_ready = 1'b1;
    endcase
  end

  task automatic clear_graph();
    for (int i = 0; i < N; i++) begin
      vpred[i] = IW'(i);
      vw[i]    = 0;
      for (int j = 0; j < N; j++) adj[i][j] = 0;
    end
  endtask

  task automatic setup_tri();
    clear_graph();
    adj[1][2] = -3; adj[2][3] = -3; adj[3][1] = -3;
    vw[0] = INF; vw[1] = -9; vw[2] = -12; vw[3] = -15;
    vpred[0] = 0; vpred[1] = 3; vpred[2] = 1; vpred[3] = 2;
  endtask

  task automatic start_run();
    @(posedge clk); #1;
    bellman_done = 1'b0;
    detect_reset = 1'b1;
    @(posedge clk); #1;
    detect_reset = 1'b0;
    beats.delete();
    valid_cycles = 0;
    stall_cnt = 0;
    bellman_done = 1'b1;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end while (!detect_done && cyc < budget);
    chk("done_within_budget", detect_done, 1);
  endtask

  // Reference: first relaxable edge in row-major order, N pred hops, then follow preds around.
  function automatic void model();
    bit hit = 0;
    int v = 0, u;
    exp_v.delete();
    exp_found = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (!hit && adj[i][j] != 0 && vw[i] != INF &&
            longint'(vw[i]) + longint'(adj[i][j]) < longint'(vw[j])) begin
          hit = 1; v = j;
        end
    if (!hit) return;
    repeat (N) v = int'(vpred[v]);
    u = v;
    do begin exp_v.push_back(u); u = int'(vpred[u]); end while (u != v && exp_v.size() < N);
    exp_found = (u == v);
  endfunction

  task automatic check_stream(input string tag, input bit closes);
    chk({tag, "_beats"}, beats.size(), exp_v.size());
    for (int k = 0; k < beats.size() && k < exp_v.size(); k++) begin
      chk($sformatf("%s_vtx%0d", tag, k), beats[k].vtx, exp_v[k]);
      chk($sformatf("%s_last%0d", tag, k), beats[k].last, closes && (k == exp_v.size() - 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, cyc_valid, 0);
    chk({tag, "_last"}, cyc_last, 0);
    chk({tag, "_vertex"}, cyc_vertex, 0);
    chk({tag, "_found"}, cycle_found, 0);
    chk({tag, "_error"}, cycle_error, 0);
    chk({tag, "_done"}, detect_done, 0);
    chk({tag, "_addrs"}, {addr_a, addr_b, row, col}, 0);
  endtask

  vec_t vecs[7];
  int cyc;

  initial begin
    vecs[0] = '{32'd0,        -32'sd1,      32'd0,        1'b1};
    vecs[1] = '{32'h7FFFFFFF, -32'sd5,      32'd0,        1'b0};
    vecs[2] = '{32'h80000000, -32'sd1,      32'h80000000, 1'b1};
    vecs[3] = '{32'h7FFFFFFE, 32'd2,        32'hFFFFFFFF, 1'b0};
    vecs[4] = '{32'd5,        -32'sd5,      32'd0,        1'b0};
    vecs[5] = '{32'd5,        -32'sd6,      32'd0,        1'b1};
    vecs[6] = '{-32'sd100,    32'd0,        32'd50,       1'b0};

    clear_graph();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Empty graph: full scan, then DONE holds with bellman_done low.
    start_run();
    wait_done(100, cyc);
    chk("empty_scan_cycles", cyc, 2 * N * N + 1);
    chk("empty_found", cycle_found, 0);
    chk("empty_error", cycle_error, 0);
    chk("empty_valid_cycles", valid_cycles, 0);
    bellman_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("done_hold", {detect_done, cyc_valid, cycle_found}, 3'b100);

    // Single edge 0->1 in a 2-cycle pred graph: compare rule incl. sentinel and overflow.
    foreach (vecs[k]) begin
      clear_graph();
      vpred[0] = 1; vpred[1] = 0;
      vw[0] = vecs[k].sw; vw[1] = vecs[k].dw; adj[0][1] = vecs[k].e;
      start_run();
      wait_done(200, cyc);
      chk($sformatf("vec%0d_found", k), cycle_found, vecs[k].found);
      chk($sformatf("vec%0d_beats", k), beats.size(), vecs[k].found ? 2 : 0);
    end

    // Triangle cycle; bellman_done drops mid-scan.
    setup_tri();
    start_run();
    repeat (3) @(posedge clk);
    #1 bellman_done = 1'b0;
    wait_done(400, cyc);
    exp_v = '{3, 2, 1};
    chk("tri_found", cycle_found, 1);
    chk("tri_error", cycle_error, 0);
    check_stream("tri", 1'b1);

    // Same, stalled 5 cycles on beat 2.
    ready_mode = 2;
    start_run();
    wait_done(400, cyc);
    ready_mode = 0;
    chk("stall_cycles", stall_cnt, 5);
    chk("stall_found", cycle_found, 1);
    check_stream("stall", 1'b1);

    // Preds rewritten after the walk so the emit chain never returns to start.
    clear_graph();
    vpred[0] = 0; vpred[1] = 2; vpred[2] = 3; vpred[3] = 0;
    adj[0][1] = -1;
    start_run();
    repeat (13) @(posedge clk);
    #1 vpred[0] = 1; vpred[3] = 1;
    wait_done(400, cyc);
    exp_v = '{0, 1, 2, 3};
    chk("open_error", cycle_error, 1);
    chk("open_found", cycle_found, 0);
    check_stream("open", 1'b0);

    // Reset in the middle of the walk, then a clean rerun.
    setup_tri();
    start_run();
    repeat (31) @(posedge clk);
    #1 detect_reset = 1'b1;
    @(posedge clk);
    #1 detect_reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midwalk_reset");
    wait_done(400, cyc);
    exp_v = '{3, 2, 1};
    chk("rerun_found", cycle_found, 1);
    check_stream("rerun", 1'b1);

    // Random graphs, random backpressure.
    ready_mode = 1;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++) begin
        vpred[i] = IW'($urandom_range(0, N - 1));
        vw[i] = ($urandom_range(0, 5) == 0) ? INF : int'($urandom_range(0, 40)) - 20;
        for (int j = 0; j < N; j++)
          adj[i][j] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 20)) - 10 : 0;
      end
      model();
      start_run();
      wait_done(600, cyc);
      chk($sformatf("rnd%0d_found", it), cycle_found, exp_found);
      chk($sformatf("rnd%0d_error", it), cycle_error, 0);
      check_stream($sformatf("rnd%0d", it), 1'b1);
    end
    ready_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cycle_detect.md
CYCLE_DETECT -- requirements
Module: cycle_detect

Interface
REQ-001 Parameter NODES, default 16, vertex count; NODES SHALL be at least 2.
REQ-002 Parameter IDX_W, default 4, vertex index width; 2^IDX_W SHALL be at least NODES.
REQ-003 Parameter WEIGHT_W, default 32, signed edge/vertex weight width.
REQ-004 clk  in  1  single clock, all logic on its rising edge.
REQ-005 detect_reset  in  1  synchronous, active-high reset.
REQ-006 bellman_done  in  1  level; high = relaxation stage finished, vertex memory stable.
REQ-007 vertmat_addr_a  out  IDX_W  read address, vertex memory port A.
REQ-008 vertmat_addr_b  out  IDX_W  read address, vertex memory port B.
REQ-009 vertmat_q_a  in  IDX_W+WEIGHT_W  port A data {pred, weight}, 1-cycle read latency.
REQ-010 vertmat_q_b  in  IDX_W+WEIGHT_W  port B data {pred, weight}, 1-cycle read latency.
REQ-011 adjmat_row_addr  out  IDX_W  edge source index.
REQ-012 adjmat_col_addr  out  IDX_W  edge destination index.
REQ-013 adjmat_q  in  WEIGHT_W  signed edge weight, 1-cycle latency; 0 = no edge.
REQ-014 cyc_vertex  out  IDX_W  emitted cycle vertex.
REQ-015 cyc_valid  out  1  cyc_vertex valid.
REQ-016 cyc_last  out  1  final vertex of the cycle.
REQ-017 cyc_ready  in  1  consumer accepts when high with cyc_valid.
REQ-018 cycle_found  out  1  negative cycle detected.
REQ-019 cycle_error  out  1  predecessor chain failed to close.
REQ-020 detect_done  out  1  stage complete; held until reset.

Function
REQ-021 Block SHALL never write either memory; it issues read addresses only.
REQ-022 States SHALL be IDLE, CHECK_ADDR, CHECK_CMP, WALK_ADDR, WALK_STEP, EMIT, DONE.
REQ-023 IDLE SHALL go to CHECK_ADDR, with i=0 and j=0, on the first cycle bellman_done is high.
REQ-024 CHECK_ADDR SHALL drive adjmat (i,j), vertmat_addr_a=i and vertmat_addr_b=j, then go to CHECK_CMP; each edge SHALL take exactly 2 cycles.
REQ-025 CHECK_CMP violation: e!=0, svw!=2^(WEIGHT_W-1)-1 (infinity sentinel), and svw+e<dvw in a (WEIGHT_W+1)-bit signed sum.
REQ-026 On a violation, block SHALL latch v=j, set counter n=0, and go to WALK_ADDR.
REQ-027 With no violation, j SHALL increment; at j=NODES-1, j SHALL wrap to 0 and i increment; after edge (NODES-1,NODES-1), block SHALL go to DONE with cycle_found=0.
REQ-028 Worst-case CHECK duration SHALL be 2*NODES*NODES cycles.
REQ-029 WALK SHALL replace v with pred(v) read on port A, 2 cycles per step, exactly NODES times, so v lies on the cycle; then set start=v and go to EMIT.
REQ-030 EMIT SHALL present cyc_vertex=v with cyc_valid=1. On cyc_valid&&cyc_ready, v SHALL become pred(v); pred SHALL be fetched with 1-cycle latency, deasserting cyc_valid for one cycle between beats.
REQ-031 While cyc_valid=1 and cyc_ready=0, cyc_vertex, cyc_valid and cyc_last SHALL hold stable.
REQ-032 cyc_last SHALL be 1 on the beat whose pred equals start; after its handshake, block SHALL set cycle_found=1 and go to DONE.
REQ-033 If NODES beats are accepted without cyc_last, block SHALL set cycle_error=1 and cycle_found=0, deassert cyc_valid, and go to DONE.
REQ-034 DONE SHALL hold detect_done=1, cyc_valid=0, and the flags, until detect_reset; bellman_done SHALL be ignored.
REQ-035 A bellman_done drop after leaving IDLE SHALL not affect operation.

Reset
REQ-036 detect_reset high SHALL, at the next clock edge and from any state, set state=IDLE and i=j=n=0.
REQ-037 The same reset SHALL clear cyc_valid, cyc_last, cycle_found, cycle_error and detect_done, and set cyc_vertex and all addresses to 0.
REQ-038 Reset SHALL take priority over every other event in the same cycle, including a pending handshake.

Verification
REQ-039 NODES=4, adjmat all 0, bellman_done=1 -> detect_done=1 after 32 CHECK cycles, cycle_found=0, no cyc_valid pulse.
REQ-040 Edges 1->2=-3, 2->3=-3, 3->1=-3; weights w1=-9, w2=-12, w3=-15; preds 2<-1, 3<-2, 1<-3 -> violation on (3,1); emitted stream is a rotation of {3,2,1}, 3 beats, cyc_last on the third; cycle_found=1.
REQ-041 Same stimulus with cyc_ready=0 for 5 cycles during beat 2 -> cyc_vertex/cyc_valid held constant, no beat lost or duplicated.
REQ-042 Source weight 0x7FFFFFFF with edge -5 to a vertex of weight 0, no other edges -> no violation, cycle_found=0.
REQ-043 Predecessor chain 1->2->3->0->0 (0 self-pred, walk lands on 0, start=0) with a forced violation, and memory altered after WALK so the emit chain never returns to start -> cycle_error=1 after 4 accepted beats, cycle_found=0.
REQ-044 detect_reset asserted mid-WALK -> next cycle all outputs at reset values; with bellman_done still high, block restarts CHECK from (0,0).
